// File: rtl/irrigation_pkg.sv
// Shared types and limits for the irrigation cycle controller.
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned SEC_D_MAX = 5;
    localparam int unsigned MIN_U_MAX = 9;
    localparam int unsigned MIN_D_MAX = 3;

    localparam int unsigned MIN_D_W = 2;
    localparam int unsigned MIN_U_W = 4;
    localparam int unsigned SEC_D_W = 3;

    // Countdown value mm:s (seconds in 10 s units), BCD digits
    typedef struct packed {
        logic [MIN_D_W-1:0] min_d;
        logic [MIN_U_W-1:0] min_u;
        logic [SEC_D_W-1:0] sec_d;
    } bcd_time_t;

    function automatic bit preset_valid(int unsigned min_d, int unsigned min_u,
                                        int unsigned sec_d);
        return (min_d <= MIN_D_MAX) && (min_u <= MIN_U_MAX) && (sec_d <= SEC_D_MAX);
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Three-digit BCD countdown (mm:s) with clear, load and saturating decrement.
module bcd_countdown
    import irrigation_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      clear,
    input  logic      load,
    input  logic      dec,
    input  bcd_time_t load_value,
    output bcd_time_t count,
    output logic      zero
);

    bcd_time_t count_nxt;

    assign zero = (count.min_d == '0) && (count.min_u == '0) && (count.sec_d == '0);

    // Priority clear > load > dec; decrement never wraps below 00:0
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = load_value;
        end else if (dec && !zero) begin
            if (count.sec_d != '0) begin
                count_nxt.sec_d = count.sec_d - SEC_D_W'(1);
            end else begin
                count_nxt.sec_d = SEC_D_W'(SEC_D_MAX);
                if (count.min_u != '0) begin
                    count_nxt.min_u = count.min_u - MIN_U_W'(1);
                end else begin
                    count_nxt.min_u = MIN_U_W'(MIN_U_MAX);
                    count_nxt.min_d = count.min_d - MIN_D_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/irrigation_cycle_controller.sv
// Irrigation cycle sequencer: loads a mode preset, drives the valve, counts down on 10 s ticks.
// Optional pause support is enabled by defining IRRIG_PAUSE_EN.
module irrigation_cycle_controller
    import irrigation_pkg::*;
#(
    parameter int unsigned SPRK_MIN_D = 1,
    parameter int unsigned SPRK_MIN_U = 5,
    parameter int unsigned SPRK_SEC_D = 0,
    parameter int unsigned DRIP_MIN_D = 3,
    parameter int unsigned DRIP_MIN_U = 0,
    parameter int unsigned DRIP_SEC_D = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_10s,
    input  logic       irrigation_request,
    input  logic       splinker_mode_on,
    input  logic       conflicting_values,
    input  logic       stop_button_n,
`ifdef IRRIG_PAUSE_EN
    input  logic       pause,
`endif
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic       busy,
    output logic       done
);

    if (!preset_valid(SPRK_MIN_D, SPRK_MIN_U, SPRK_SEC_D) ||
        !preset_valid(DRIP_MIN_D, DRIP_MIN_U, DRIP_SEC_D)) begin : g_bad_preset
        $error("irrigation_cycle_controller: preset digit exceeds BCD limit");
    end

    localparam bcd_time_t SPRK_PRESET = '{min_d: MIN_D_W'(SPRK_MIN_D),
                                          min_u: MIN_U_W'(SPRK_MIN_U),
                                          sec_d: SEC_D_W'(SPRK_SEC_D)};
    localparam bcd_time_t DRIP_PRESET = '{min_d: MIN_D_W'(DRIP_MIN_D),
                                          min_u: MIN_U_W'(DRIP_MIN_U),
                                          sec_d: SEC_D_W'(DRIP_SEC_D)};
    localparam bit SPRK_ZERO = (SPRK_MIN_D == 0) && (SPRK_MIN_U == 0) && (SPRK_SEC_D == 0);
    localparam bit DRIP_ZERO = (DRIP_MIN_D == 0) && (DRIP_MIN_U == 0) && (DRIP_SEC_D == 0);

    state_t    state, state_nxt;
    logic      mode_q, mode_nxt;
    logic      abort_c, pause_c, last_c;
    logic      cnt_clear, cnt_load, cnt_dec, cnt_zero;
    bcd_time_t count;

    assign abort_c = conflicting_values | ~stop_button_n | ~irrigation_request;
`ifdef IRRIG_PAUSE_EN
    assign pause_c = pause;
`else
    assign pause_c = 1'b0;
`endif
    // Count is at 00:1, so the next decrement finishes the cycle
    assign last_c = (count.min_d == '0) && (count.min_u == '0) && (count.sec_d == SEC_D_W'(1));

    bcd_countdown u_countdown (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (splinker_mode_on ? SPRK_PRESET : DRIP_PRESET),
        .count      (count),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (!abort_c) state_nxt = LOAD;
            end
            LOAD: begin
                mode_nxt  = splinker_mode_on;
                cnt_load  = 1'b1;
                state_nxt = (splinker_mode_on ? SPRK_ZERO : DRIP_ZERO) ? DONE : RUN;
            end
            RUN: begin
                if (abort_c) begin
                    cnt_clear = 1'b1;
                    state_nxt = IDLE;
                end else if (pause_c) begin
                    state_nxt = PAUSE;
                end else if (cnt_zero) begin
                    state_nxt = DONE;
                end else if (tick_10s) begin
                    cnt_dec = 1'b1;
                    if (last_c) state_nxt = DONE;
                end
            end
            PAUSE: begin
                if (abort_c) begin
                    cnt_clear = 1'b1;
                    state_nxt = IDLE;
                end else if (!pause_c) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (!irrigation_request) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs registered from next state so they line up with the state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            mode_q          <= 1'b0;
            valve_sprinkler <= 1'b0;
            valve_drip      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            mode_q          <= mode_nxt;
            valve_sprinkler <= (state_nxt == RUN) && mode_nxt;
            valve_drip      <= (state_nxt == RUN) && !mode_nxt;
            busy            <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == PAUSE);
            done            <= (state_nxt == DONE) && (state != DONE);
        end
    end

    assign minutes_d = count.min_d;
    assign minutes_u = count.min_u;
    assign seconds_d = count.sec_d;

endmodule

// File: tb/tb_irrigation_cycle_controller.sv
// Directed self-checking bench for irrigation_cycle_controller (define IRRIG_PAUSE_EN for pause tests).
module tb_irrigation_cycle_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick_10s;
    logic       irrigation_request;
    logic       splinker_mode_on;
    logic       conflicting_values;
    logic       stop_button_n;
`ifdef IRRIG_PAUSE_EN
    logic       pause;
`endif
    logic [1:0] minutes_d;
    logic [3:0] minutes_u;
    logic [2:0] seconds_d;
    logic       valve_sprinkler;
    logic       valve_drip;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int rem;
    int vs_hi;
    int done_cnt;

    always #5 clock = ~clock;

    irrigation_cycle_controller dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .tick_10s           (tick_10s),
        .irrigation_request (irrigation_request),
        .splinker_mode_on   (splinker_mode_on),
        .conflicting_values (conflicting_values),
        .stop_button_n      (stop_button_n),
`ifdef IRRIG_PAUSE_EN
        .pause              (pause),
`endif
        .minutes_d          (minutes_d),
        .minutes_u          (minutes_u),
        .seconds_d          (seconds_d),
        .valve_sprinkler    (valve_sprinkler),
        .valve_drip         (valve_drip),
        .busy               (busy),
        .done               (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected BCD count for a number of remaining 10 s ticks
    function automatic logic [8:0] bcd_of(input int r);
        int m;
        m = r / 6;
        return {2'(m / 10), 4'(m % 10), 3'(r % 6)};
    endfunction

    function automatic logic [8:0] bcd(input int md, input int mu, input int sd);
        return {2'(md), 4'(mu), 3'(sd)};
    endfunction

    function automatic logic [8:0] cnt();
        return {minutes_d, minutes_u, seconds_d};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (valve_sprinkler) vs_hi++;
        if (done) done_cnt++;
    endtask

    // Each tick period: one idle cycle then one tick cycle; count checked against the model
    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            tick_10s = 1'b1;
            step();
            tick_10s = 1'b0;
            rem--;
            chk("count", 32'(cnt()), 32'(bcd_of(rem)));
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        tick_10s           = 1'b0;
        irrigation_request = 1'b0;
        splinker_mode_on   = 1'b1;
        conflicting_values = 1'b0;
        stop_button_n      = 1'b1;
`ifdef IRRIG_PAUSE_EN
        pause              = 1'b0;
`endif
        vs_hi    = 0;
        done_cnt = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", 32'(cnt()), 32'(0));
        chk("rst_outs", {valve_sprinkler, valve_drip, busy, done}, 4'b0000);
        reset_n = 1'b1;
        step();
        chk("idle_no_req", busy, 1'b0);

        // Sprinkler full cycle 15:0 -> 00:0
        irrigation_request = 1'b1;
        step();
        chk("load_busy", {busy, valve_sprinkler, valve_drip}, 3'b100);
        vs_hi    = 0;
        done_cnt = 0;
        step();
        chk("run_entry", 32'(cnt()), 32'(bcd(1, 5, 0)));
        chk("run_valves", {valve_sprinkler, valve_drip, busy}, 3'b101);
        rem = 90;
        run_ticks(30);
        chk("at_10_0", 32'(cnt()), 32'(bcd(1, 0, 0)));
        run_ticks(1);
        chk("borrow_09_5", 32'(cnt()), 32'(bcd(0, 9, 5)));
        run_ticks(53);
        chk("at_01_0", 32'(cnt()), 32'(bcd(0, 1, 0)));
        run_ticks(1);
        chk("borrow_00_5", 32'(cnt()), 32'(bcd(0, 0, 5)));
        run_ticks(4);
        chk("last_valve", valve_sprinkler, 1'b1);
        run_ticks(1);
        chk("done_pulse", {done, busy, valve_sprinkler}, 3'b100);
        tick_10s = 1'b1;
        step();
        tick_10s = 1'b0;
        chk("done_hold_cnt", 32'(cnt()), 32'(0));
        chk("done_once", done, 1'b0);
        repeat (3) step();
        chk("done_stay", {busy, done, valve_sprinkler}, 3'b000);
        chk("done_count", done_cnt, 1);
        chk("valve_cycles", vs_hi, 180);

        // Request low leaves DONE; high again starts a drip cycle
        irrigation_request = 1'b0;
        splinker_mode_on   = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);
        irrigation_request = 1'b1;
        step();
        chk("reload_busy", busy, 1'b1);
        step();
        chk("drip_entry", 32'(cnt()), 32'(bcd(3, 0, 0)));
        chk("drip_valves", {valve_sprinkler, valve_drip}, 2'b01);
        rem = 180;
        splinker_mode_on = 1'b1;
        run_ticks(45);
        chk("drip_22_3", 32'(cnt()), 32'(bcd(2, 2, 3)));
        chk("mode_ignored", {valve_sprinkler, valve_drip}, 2'b01);
        done_cnt = 0;
        conflicting_values = 1'b1;
        step();
        chk("conf_count", 32'(cnt()), 32'(0));
        chk("conf_outs", {valve_sprinkler, valve_drip, busy, done}, 4'b0000);
        step();
        chk("conf_stay_idle", busy, 1'b0);
        conflicting_values = 1'b0;

        // Stop button coinciding with a tick
        step();
        chk("spk_load", busy, 1'b1);
        step();
        rem = 90;
        run_ticks(1);
        chk("spk_14_5", 32'(cnt()), 32'(bcd(1, 4, 5)));
        stop_button_n = 1'b0;
        tick_10s      = 1'b1;
        step();
        tick_10s = 1'b0;
        chk("stop_count", 32'(cnt()), 32'(0));
        chk("stop_outs", {valve_sprinkler, valve_drip, busy, done}, 4'b0000);
        chk("no_done_abort", done_cnt, 0);
        stop_button_n = 1'b1;

`ifdef IRRIG_PAUSE_EN
        step();
        step();
        chk("p_entry", 32'(cnt()), 32'(bcd(1, 5, 0)));
        rem = 90;
        run_ticks(58);
        chk("p_05_2", 32'(cnt()), 32'(bcd(0, 5, 2)));
        pause = 1'b1;
        step();
        chk("p_valves", {valve_sprinkler, valve_drip, busy}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            tick_10s = 1'b1;
            step();
            tick_10s = 1'b0;
            step();
        end
        chk("p_hold", 32'(cnt()), 32'(bcd(0, 5, 2)));
        chk("p_hold_valve", valve_sprinkler, 1'b0);
        pause = 1'b0;
        step();
        chk("p_resume", valve_sprinkler, 1'b1);
        run_ticks(1);
        chk("p_05_1", 32'(cnt()), 32'(bcd(0, 5, 1)));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
